// File: rtl/mac_tile_sequencer.sv
// Sequences one N x N tile multiply: streams A/B buffer reads into the MAC and writes C.
// Element e is written (e+1)*(N+2) cycles after start is sampled; start is ignored unless IDLE.
module mac_tile_sequencer #(
    parameter int N  = 4,
    parameter int DW = 8,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] a_addr,
    input  logic [DW-1:0] a_rdata,
    output logic [AW-1:0] b_addr,
    input  logic [DW-1:0] b_rdata,
    output logic [DW-1:0] mac_a,
    output logic [DW-1:0] mac_b,
    output logic          mac_enable,
    output logic          reset_acc,
    input  logic [DW-1:0] acc_in,
    output logic          c_we,
    output logic [AW-1:0] c_addr,
    output logic [DW-1:0] c_wdata
);

    localparam int KW = $clog2(N);
    localparam logic [KW-1:0] KMAX = KW'(N - 1);

    typedef enum logic [2:0] {IDLE, CLEAR, RUN, WRITE, DONE} state_t;

    state_t        state_q, state_d;
    logic [KW-1:0] i_q, i_d, j_q, j_d, k_q, k_d;
    logic [KW-1:0] rd_k;
    logic          busy_q, busy_d, done_q, done_d;
    logic          mac_enable_q, mac_enable_d, reset_acc_q, reset_acc_d, c_we_q, c_we_d;
    logic [AW-1:0] a_addr_q, a_addr_d, b_addr_q, b_addr_d, c_addr_q, c_addr_d;

    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        j_d     = j_q;
        k_d     = k_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    i_d     = '0;
                    j_d     = '0;
                    k_d     = '0;
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                k_d     = '0;
                state_d = RUN;
            end
            RUN: begin
                if (k_q == KMAX) begin
                    state_d = WRITE;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            WRITE: begin
                k_d = '0;
                j_d = j_q + 1'b1;
                if (j_q == KMAX) begin
                    i_d = i_q + 1'b1;
                end
                if (i_q == KMAX && j_q == KMAX) begin
                    state_d = DONE;
                end else begin
                    state_d = CLEAR;
                end
            end
            DONE: begin
                i_d     = '0;
                j_d     = '0;
                k_d     = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Outputs are registered, so they are derived from the state being entered.
        busy_d       = (state_d == CLEAR) || (state_d == RUN) || (state_d == WRITE);
        done_d       = (state_d == DONE);
        reset_acc_d  = (state_d == CLEAR);
        mac_enable_d = (state_d == RUN);
        c_we_d       = (state_d == WRITE);

        // During RUN the read issued is one ahead of the operand being consumed.
        rd_k = ((state_d == RUN) && (k_d != KMAX)) ? k_d + 1'b1 : k_d;
        if (busy_d) begin
            a_addr_d = AW'({i_d, rd_k});
            b_addr_d = AW'({rd_k, j_d});
            c_addr_d = AW'({i_d, j_d});
        end else begin
            a_addr_d = '0;
            b_addr_d = '0;
            c_addr_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            i_q          <= '0;
            j_q          <= '0;
            k_q          <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            mac_enable_q <= 1'b0;
            reset_acc_q  <= 1'b0;
            c_we_q       <= 1'b0;
            a_addr_q     <= '0;
            b_addr_q     <= '0;
            c_addr_q     <= '0;
        end else begin
            state_q      <= state_d;
            i_q          <= i_d;
            j_q          <= j_d;
            k_q          <= k_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            mac_enable_q <= mac_enable_d;
            reset_acc_q  <= reset_acc_d;
            c_we_q       <= c_we_d;
            a_addr_q     <= a_addr_d;
            b_addr_q     <= b_addr_d;
            c_addr_q     <= c_addr_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign mac_enable = mac_enable_q;
    assign reset_acc  = reset_acc_q;
    assign c_we       = c_we_q;
    assign a_addr     = a_addr_q;
    assign b_addr     = b_addr_q;
    assign c_addr     = c_addr_q;

    // Buffer read data lands in the cycle the operand is needed, so it passes straight through.
    assign mac_a   = mac_enable_q ? a_rdata : '0;
    assign mac_b   = mac_enable_q ? b_rdata : '0;
    assign c_wdata = c_we_q ? acc_in : '0;

endmodule
